// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: retire FSM states and the queue entry layout
// {done, exc, wb_en, dest, value, pc} used by the queue, completion writers and retire unit.
package rob_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } retire_state_t;

  localparam int DEF_REG_W = 5;
  localparam int DEF_VAL_W = 32;
  localparam int DEF_PC_W  = 32;

  function automatic int entry_w(input int reg_w, input int val_w, input int pc_w);
    return 3 + reg_w + val_w + pc_w;
  endfunction

  function automatic int value_lsb(input int pc_w);
    return pc_w;
  endfunction

  function automatic int dest_lsb(input int val_w, input int pc_w);
    return pc_w + val_w;
  endfunction

  function automatic int wben_bit(input int reg_w, input int val_w, input int pc_w);
    return pc_w + val_w + reg_w;
  endfunction

  function automatic int exc_bit(input int reg_w, input int val_w, input int pc_w);
    return pc_w + val_w + reg_w + 1;
  endfunction

  function automatic int done_bit(input int reg_w, input int val_w, input int pc_w);
    return pc_w + val_w + reg_w + 2;
  endfunction

  localparam int PC_LSB    = 0;
  localparam int VALUE_LSB = value_lsb(DEF_PC_W);
  localparam int DEST_LSB  = dest_lsb(DEF_VAL_W, DEF_PC_W);
  localparam int WBEN_BIT  = wben_bit(DEF_REG_W, DEF_VAL_W, DEF_PC_W);
  localparam int EXC_BIT   = exc_bit(DEF_REG_W, DEF_VAL_W, DEF_PC_W);
  localparam int DONE_BIT  = done_bit(DEF_REG_W, DEF_VAL_W, DEF_PC_W);
  localparam int ENTRY_W   = entry_w(DEF_REG_W, DEF_VAL_W, DEF_PC_W);

endpackage

// File: rtl/rob_entry_unpack.sv
// Combinational field slicer for one reorder-buffer entry.
module rob_entry_unpack
  import rob_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int VAL_W   = 32,
  parameter int PC_W    = 32,
  parameter int ENTRY_W = entry_w(REG_W, VAL_W, PC_W)
) (
  input  logic [ENTRY_W-1:0] entry,
  output logic               done,
  output logic               exc,
  output logic               wb_en,
  output logic [REG_W-1:0]   dest,
  output logic [VAL_W-1:0]   value,
  output logic [PC_W-1:0]    pc
);

  localparam int L_DONE  = done_bit(REG_W, VAL_W, PC_W);
  localparam int L_EXC   = exc_bit(REG_W, VAL_W, PC_W);
  localparam int L_WBEN  = wben_bit(REG_W, VAL_W, PC_W);
  localparam int L_DEST  = dest_lsb(VAL_W, PC_W);
  localparam int L_VALUE = value_lsb(PC_W);

  assign done  = entry[L_DONE];
  assign exc   = entry[L_EXC];
  assign wb_en = entry[L_WBEN];
  assign dest  = entry[L_DEST +: REG_W];
  assign value = entry[L_VALUE +: VAL_W];
  assign pc    = entry[0 +: PC_W];

endmodule

// File: rtl/rob_retire.sv
// In-order retire unit: pops completed reorder-buffer head entries, issues one registered
// register-file write per retire, and flushes/redirects on an excepting head.
module rob_retire
  import rob_pkg::*;
#(
  parameter int               REG_W      = 5,
  parameter int               VAL_W      = 32,
  parameter int               PC_W       = 32,
  parameter logic [PC_W-1:0]  EXC_VECTOR = 32'h0000_0080,
  parameter int               CNT_W      = 32,
  parameter int               ENTRY_W    = entry_w(REG_W, VAL_W, PC_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               qEmpty_IN,
  input  logic [ENTRY_W-1:0] qData_IN,
  output logic               qPopReq_OUT,
  output logic               qFlush_OUT,
  input  logic               stall_IN,
  output logic               wbEn_OUT,
  output logic [REG_W-1:0]   wbReg_OUT,
  output logic [VAL_W-1:0]   wbData_OUT,
  output logic               redirect_OUT,
  output logic [PC_W-1:0]    redirectPc_OUT,
  output logic [PC_W-1:0]    excPc_OUT,
  output logic [CNT_W-1:0]   retireCount_OUT
);

  retire_state_t    state, state_nxt;
  logic             head_done, head_exc, head_wb_en;
  logic [REG_W-1:0] head_dest;
  logic [VAL_W-1:0] head_value;
  logic [PC_W-1:0]  head_pc;
  logic             head_ready, do_retire, take_exc, in_flush;

  rob_entry_unpack #(
    .REG_W   (REG_W),
    .VAL_W   (VAL_W),
    .PC_W    (PC_W),
    .ENTRY_W (ENTRY_W)
  ) u_unpack (
    .entry (qData_IN),
    .done  (head_done),
    .exc   (head_exc),
    .wb_en (head_wb_en),
    .dest  (head_dest),
    .value (head_value),
    .pc    (head_pc)
  );

  // Head qualification, pop/flush strobes and next state; stall only matters in RUN.
  always_comb begin
    state_nxt  = ST_RUN;
    head_ready = 1'b0;
    do_retire  = 1'b0;
    take_exc   = 1'b0;
    in_flush   = 1'b0;
    case (state)
      ST_RUN: begin
        head_ready = !qEmpty_IN && head_done && !stall_IN;
        do_retire  = head_ready && !head_exc;
        take_exc   = head_ready && head_exc;
        state_nxt  = take_exc ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: begin
        in_flush  = 1'b1;
        state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    qPopReq_OUT = do_retire && !reset;
    qFlush_OUT  = in_flush && !reset;
  end

  // State register and registered writeback / redirect / counter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_RUN;
      wbEn_OUT        <= 1'b0;
      wbReg_OUT       <= {REG_W{1'b0}};
      wbData_OUT      <= {VAL_W{1'b0}};
      redirect_OUT    <= 1'b0;
      redirectPc_OUT  <= {PC_W{1'b0}};
      excPc_OUT       <= {PC_W{1'b0}};
      retireCount_OUT <= {CNT_W{1'b0}};
    end else begin
      state        <= state_nxt;
      wbEn_OUT     <= do_retire && head_wb_en;
      redirect_OUT <= in_flush;
      if (do_retire) begin
        wbReg_OUT       <= head_dest;
        wbData_OUT      <= head_value;
        retireCount_OUT <= retireCount_OUT + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (take_exc) begin
        excPc_OUT <= head_pc;
      end
      if (in_flush) begin
        redirectPc_OUT <= EXC_VECTOR;
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Randomized + directed bench for rob_retire against a queue-level reference model;
// a second instance with a 4-bit counter exercises counter wrap.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        reset, q_empty, stall;
  logic [71:0] q_data;

  logic        pop, flush, wb_en, redirect;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, redirect_pc, exc_pc, count;
  logic        pop4, flush4, wb_en4, redirect4;
  logic [4:0]  wb_reg4;
  logic [31:0] wb_data4, redirect_pc4, exc_pc4;
  logic [3:0]  count4;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic        m_wb_en = 1'b0, m_redirect = 1'b0;
  logic [4:0]  m_wb_reg = 5'd0;
  logic [31:0] m_wb_data = 32'd0, m_redir_pc = 32'd0, m_exc_pc = 32'd0;
  longint      m_count = 0;
  int          flush_left = 0;  // 2: flush cycle, 1: recovery cycle, 0: retiring

  always #5 clk = ~clk;

  rob_retire dut (
    .clk(clk), .reset(reset), .qEmpty_IN(q_empty), .qData_IN(q_data),
    .qPopReq_OUT(pop), .qFlush_OUT(flush), .stall_IN(stall),
    .wbEn_OUT(wb_en), .wbReg_OUT(wb_reg), .wbData_OUT(wb_data),
    .redirect_OUT(redirect), .redirectPc_OUT(redirect_pc), .excPc_OUT(exc_pc),
    .retireCount_OUT(count)
  );

  rob_retire #(.CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .qEmpty_IN(q_empty), .qData_IN(q_data),
    .qPopReq_OUT(pop4), .qFlush_OUT(flush4), .stall_IN(stall),
    .wbEn_OUT(wb_en4), .wbReg_OUT(wb_reg4), .wbData_OUT(wb_data4),
    .redirect_OUT(redirect4), .redirectPc_OUT(redirect_pc4), .excPc_OUT(exc_pc4),
    .retireCount_OUT(count4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: drive at negedge, check strobes, clock, update model, check registers.
  task automatic step(input logic rst, input logic e, input logic d, input logic x,
                      input logic w, input logic [4:0] dst, input logic [31:0] val,
                      input logic [31:0] pc, input logic stl);
    logic ready, exp_pop, exp_flush;
    reset   = rst;
    q_empty = e;
    stall   = stl;
    q_data  = {d, x, w, dst, val, pc};
    ready     = !rst && flush_left == 0 && !e && d && !stl;
    exp_pop   = ready && !x;
    exp_flush = !rst && flush_left == 2;
    #1;
    check("pop", pop, exp_pop);
    check("flush", flush, exp_flush);
    check("pop_w4", pop4, exp_pop);
    check("flush_w4", flush4, exp_flush);
    @(posedge clk);
    if (rst) begin
      m_wb_en = 1'b0; m_redirect = 1'b0; m_wb_reg = 5'd0; m_wb_data = 32'd0;
      m_redir_pc = 32'd0; m_exc_pc = 32'd0; m_count = 0; flush_left = 0;
    end else begin
      m_wb_en    = exp_pop && w;
      m_redirect = (flush_left == 2);
      if (flush_left == 2) m_redir_pc = 32'h80;
      if (exp_pop) begin
        m_wb_reg  = dst;
        m_wb_data = val;
        m_count++;
      end
      if (flush_left > 0) flush_left--;
      else if (ready && x) begin
        m_exc_pc   = pc;
        flush_left = 2;
      end
    end
    #1;
    check("wb_en", wb_en, m_wb_en);
    check("wb_reg", wb_reg, m_wb_reg);
    check("wb_data", wb_data, m_wb_data);
    check("redirect", redirect, m_redirect);
    check("redirect_pc", redirect_pc, m_redir_pc);
    check("exc_pc", exc_pc, m_exc_pc);
    check("count", count, m_count % 64'h1_0000_0000);
    check("count_w4", count4, m_count % 16);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1234_5678, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; q_empty = 1'b1; stall = 1'b0; q_data = 72'd0;
    @(negedge clk);
    // reset held two cycles with empty queue
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    // single retire
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h100, 1'b0);
    idle(1);
    // three back-to-back retires
    for (int i = 1; i <= 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'(i), 32'hA000_0000 + 32'(i), 32'h104 + 32'(i), 1'b0);
    idle(1);
    // head not done for 4 cycles, then done
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 32'h120, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 32'h120, 1'b0);
    // stall with a ready head (including an excepting one), then release
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h88, 32'h124, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 32'h124, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 32'h124, 1'b0);
    // exception: stall is ignored in flush/recover; retire resumes afterwards
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 32'h204, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 32'h208, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 32'h208, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 32'h208, 1'b0);
    // empty flag masks a ready-looking head
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 32'h20c, 1'b0);
    // reset during flush aborts without a second flush
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 32'h300, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 32'h304, 1'b0);
    idle(3);
    // 17 retires wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'(i % 3 != 0), 5'(i), $urandom, 32'h400 + 32'(4 * i), 1'b0);
    check("wrap_w4", count4, 4'd1);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 5'($urandom), $urandom,
           $urandom, $urandom_range(0, 5) == 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
